// File: rtl/padder_pkg.sv
// -----------------------------------------------------------------------------
// padder_pkg
// Shared constants for the block padder: word width, block (rate) width,
// words per block and the two pad marker bytes.
// -----------------------------------------------------------------------------
package padder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RATE_W = 576;
    localparam int unsigned WORDS  = 18;

    // First pad byte appended right after the message bytes.
    localparam logic [7:0] PAD_FIRST = 8'h01;
    // Final pad bit, OR-ed into the last byte of the block.
    localparam logic [7:0] PAD_LAST  = 8'h80;

endpackage : padder_pkg

// File: rtl/padder_word_pad.sv
// -----------------------------------------------------------------------------
// padder_word_pad
// Combinational padding of the final message word: keeps the valid leading
// bytes and appends the first pad byte, zero-filling the remainder.
//
// Ports:
//   i_word     [31:0]  final message word, first byte in [31:24]
//   i_byte_num [1:0]   number of valid bytes in i_word (0..3)
//   o_word     [31:0]  padded word
// -----------------------------------------------------------------------------
module padder_word_pad
    import padder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_num,
    output logic [31:0] o_word
);

    // Select how many message bytes survive before the pad byte.
    always_comb begin
        o_word = 32'h0000_0000;
        case (i_byte_num)
            2'd0:    o_word = {PAD_FIRST, 24'h00_0000};
            2'd1:    o_word = {i_word[31:24], PAD_FIRST, 16'h0000};
            2'd2:    o_word = {i_word[31:16], PAD_FIRST, 8'h00};
            2'd3:    o_word = {i_word[31:8], PAD_FIRST};
            default: o_word = 32'h0000_0000;
        endcase
    end

endmodule : padder_word_pad

// File: rtl/padder.sv
// -----------------------------------------------------------------------------
// padder
// Collects 32-bit message words into a 576-bit block (18 words), appends the
// 0x01 ... 0x80 padding after the final word and presents the block to a
// consumer that acknowledges it with f_ack. One message per reset.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   in   [31:0]  message word, first byte in in[31:24]
//   in_ready     in is valid this cycle
//   is_last      in is the final message word
//   byte_num[1:0] valid bytes in the final word (only used with is_last)
//   f_ack        consumer has taken the block on out
//   buffer_full  block holds 18 words, no word is accepted
//   out [575:0]  padded block, first accepted word in out[575:544]
//   out_ready    out is valid (same as buffer_full)
//
// Configuration macro:
//   PADDER_ASSERT_EN  compiles embedded protocol assertions when defined.
// -----------------------------------------------------------------------------
module padder
    import padder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in,
    input  logic              in_ready,
    input  logic              is_last,
    input  logic [1:0]        byte_num,
    input  logic              f_ack,
    output logic              buffer_full,
    output logic [575:0]      out,
    output logic              out_ready
);

    logic [WORDS-1:0]  r_cnt;       // thermometer fill count
    logic              r_pad_state; // inserting zero pad words
    logic              r_done;      // message finished, block delivered
    logic [RATE_W-1:0] r_out;       // block shift register

    logic              w_buffer_full;
    logic              w_update;
    logic              w_final_word;
    logic [WORD_W-1:0] w_padded;
    logic [WORD_W-1:0] w_base;
    logic [WORD_W-1:0] w_word;

    assign w_buffer_full = r_cnt[WORDS-1];
    assign w_update      = (in_ready | r_pad_state) & ~w_buffer_full & ~r_done;

    padder_word_pad u_word_pad (
        .i_word     (in),
        .i_byte_num (byte_num),
        .o_word     (w_padded)
    );

    // Choose between zero pad word, raw message word and padded final word.
    always_comb begin
        w_base = {WORD_W{1'b0}};
        if (r_pad_state) begin
            w_base = {WORD_W{1'b0}};
        end else if (!is_last) begin
            w_base = in;
        end else begin
            w_base = w_padded;
        end
    end

    // The 18th word of a padded block always carries the closing 0x80 bit,
    // OR-ed so that a 0x01 pad byte in the same position becomes 0x81.
    assign w_final_word = r_cnt[WORDS-2] & (r_pad_state | is_last);
    assign w_word       = w_base | {24'h00_0000, (w_final_word ? PAD_LAST : 8'h00)};

    // Fill counter: advances per accepted word, cleared when the block is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {WORDS{1'b0}};
        end else if (w_update) begin
            r_cnt <= {r_cnt[WORDS-2:0], 1'b1};
        end else if (f_ack && w_buffer_full) begin
            r_cnt <= {WORDS{1'b0}};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Block shift register: new words enter at the bottom.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= {RATE_W{1'b0}};
        end else if (w_update) begin
            r_out <= {r_out[RATE_W-WORD_W-1:0], w_word};
        end else begin
            r_out <= r_out;
        end
    end

    // Padding phase starts once the final message word has been accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pad_state <= 1'b0;
        end else if (w_update && is_last && !r_pad_state) begin
            r_pad_state <= 1'b1;
        end else begin
            r_pad_state <= r_pad_state;
        end
    end

    // Message is finished once the padded block has been filled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (r_pad_state && w_buffer_full) begin
            r_done <= 1'b1;
        end else begin
            r_done <= r_done;
        end
    end

    assign buffer_full = w_buffer_full;
    assign out_ready   = w_buffer_full;
    assign out         = r_out;

`ifdef PADDER_ASSERT_EN
    // Protocol checks, compiled only when assertions are enabled.
    a_ready_eq_full : assert property (@(posedge clk) disable iff (!reset)
        out_ready == buffer_full);
    a_no_update_full : assert property (@(posedge clk) disable iff (!reset)
        !(w_update && w_buffer_full));
    a_byte_num_known : assert property (@(posedge clk) disable iff (!reset)
        (is_last && in_ready) |-> !$isunknown(byte_num));
`endif

endmodule : padder

// File: tb/tb_padder.sv
module tb_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_w;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         f_ack;
    logic         buffer_full;
    logic [575:0] out_w;
    logic         out_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [575:0] sb[$];

    localparam logic [575:0] E_EMPTY = {8'h01, 560'h0, 8'h80};
    localparam logic [575:0] E_568   = {{8{64'h1234567890ABCDEF}}, 64'h1234567890ABCD81};
    localparam logic [575:0] E_512   = {{8{64'h1234567890ABCDEF}}, 64'h0100000000000080};
    localparam logic [575:0] E_BLK1  = {9{64'h1234567890ABCDEF}};
    localparam logic [575:0] E_BLK2  = {{8{64'h1234567890ABCDEF}}, 64'h1234567890AB0180};

    padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_w),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .f_ack       (f_ack),
        .buffer_full (buffer_full),
        .out         (out_w),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        in_w     = 32'h0;
        f_ack    = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        idle();
        #12;
        check({tag, "_rst_full"},  {575'h0, buffer_full}, 576'h0);
        check({tag, "_rst_ready"}, {575'h0, out_ready},   576'h0);
        check({tag, "_rst_out"},   out_w,                 576'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic feed(input logic [31:0] w, input logic last, input logic [1:0] bn);
        in_ready = 1'b1;
        in_w     = w;
        is_last  = last;
        byte_num = bn;
        step();
    endtask

    // Alternating 12345678 / 90ABCDEF words; optionally the last one flagged.
    task automatic feed_msg(input int n, input logic [1:0] last_bn, input logic has_last);
        for (int i = 0; i < n; i++) begin
            feed((i % 2 == 1) ? 32'h90ABCDEF : 32'h12345678,
                 has_last && (i == n - 1), last_bn);
        end
        idle();
    endtask

    // Bounded wait for out_ready, then compare against the scoreboard head.
    task automatic wait_full(input string tag, input int budget);
        logic [575:0] exp;
        int k = 0;
        while (!buffer_full && k < budget) begin
            step();
            k++;
        end
        check({tag, "_ready"}, {575'h0, out_ready}, 576'h1);
        exp = (sb.size() > 0) ? sb.pop_front() : 576'h0;
        check({tag, "_block"}, out_w, exp);
    endtask

    task automatic ack(input string tag);
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check({tag, "_ack_ready"}, {575'h0, out_ready}, 576'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        #2;
        do_reset("init");

        // Empty message: two cycles of is_last with byte_num 0.
        sb.push_back(E_EMPTY);
        in_ready = 1'b1; is_last = 1'b1; in_w = 32'h0; byte_num = 2'd0;
        step();
        step();
        idle();
        wait_full("empty", 40);
        ack("empty");
        for (int i = 0; i < 5; i++) begin
            step();
            check("empty_hold", {575'h0, buffer_full}, 576'h0);
        end

        // 568-bit message: pad byte and final bit share the last byte.
        do_reset("m568");
        sb.push_back(E_568);
        feed_msg(18, 2'd3, 1'b1);
        wait_full("m568", 10);
        ack("m568");

        // 512-bit message: one-word padding, exact latency check.
        do_reset("m512");
        sb.push_back(E_512);
        feed_msg(16, 2'd0, 1'b0);
        feed(32'h12345678, 1'b1, 2'd0);
        idle();
        check("m512_not_yet", {575'h0, buffer_full}, 576'h0);
        step();
        check("m512_latency", {575'h0, buffer_full}, 576'h1);
        wait_full("m512", 10);
        ack("m512");

        // Two blocks with back-pressure while full.
        do_reset("two");
        sb.push_back(E_BLK1);
        feed_msg(18, 2'd0, 1'b0);
        wait_full("blk1", 10);
        in_ready = 1'b1; in_w = 32'd999;
        for (int i = 0; i < 2; i++) begin
            step();
            check("blk1_stall_full", {575'h0, buffer_full}, 576'h1);
            check("blk1_stall_out", out_w, E_BLK1);
        end
        idle();
        ack("blk1");
        sb.push_back(E_BLK2);
        feed_msg(18, 2'd2, 1'b1);
        wait_full("blk2", 10);
        ack("blk2");
        for (int i = 0; i < 10; i++) begin
            step();
            check("blk2_after", {575'h0, out_ready}, 576'h0);
        end

        // Asynchronous reset mid-block, then a full message.
        do_reset("mid");
        feed_msg(5, 2'd0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("mid_async_full", {575'h0, buffer_full}, 576'h0);
        check("mid_async_out", out_w, 576'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.push_back(E_568);
        feed_msg(18, 2'd3, 1'b1);
        wait_full("mid_msg", 10);
        ack("mid_msg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_padder

// File: doc/padder.md
PADDER -- requirements
Module: padder

Interface
REQ-001 The module SHALL use no parameters; widths are fixed (32-bit word, 576-bit rate, 18 words per block).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in  input  32  message word; first-fed byte in in[31:24].
REQ-005 in_ready  input  1  in is valid this cycle.
REQ-006 is_last  input  1  current word is the final message word.
REQ-007 byte_num  input  2  valid bytes in the final word (0..3); ignored unless is_last.
REQ-008 f_ack  input  1  consumer has taken the block on out.
REQ-009 buffer_full  output  1  block buffer holds 18 words; no word accepted.
REQ-010 out  output  576  padded block; first accepted word in out[575:544].
REQ-011 out_ready  output  1  out is valid; SHALL equal buffer_full.

Function
REQ-012 Internals: 18-bit thermometer fill counter cnt, flag pad_state, flag done, 576-bit shift register out; buffer_full = cnt[17].
REQ-013 update = (in_ready | pad_state) & ~buffer_full & ~done; on update, out <= {out[543:0], w} and cnt <= {cnt[16:0], 1}.
REQ-014 Word w: if pad_state, 32'h0; else if ~is_last, in; else pad(in, byte_num).
REQ-015 pad: byte_num 0 -> 32'h01000000; 1 -> {in[31:24], 24'h010000}; 2 -> {in[31:16], 16'h0100}; 3 -> {in[31:8], 8'h01}.
REQ-016 If the word being shifted is the 18th of the block (cnt[16]=1) and (pad_state or is_last), w[7] SHALL be forced to 1 (final 0x80 pad bit, OR-combined, e.g. 0x...01 becomes 0x...81).
REQ-017 pad_state SHALL set on an update with is_last=1 and pad_state=0; while set, zero words are inserted without in_ready until full; in and is_last are ignored.
REQ-018 done SHALL set on the clock edge where pad_state=1 and buffer_full=1; once set, no further words are accepted until reset (one message per reset).
REQ-019 f_ack=1 while buffer_full=1 SHALL clear cnt next edge (out_ready falls next cycle); f_ack while not full has no effect; out contents are not cleared.
REQ-020 While buffer_full=1, in/in_ready SHALL NOT be consumed; the same word must be re-presented after f_ack.
REQ-021 Latency: out_ready rises the cycle after the 18th word is shifted in.
REQ-022 Message of 17 words + last: padding fits in final word; message ending exactly on block boundary cannot occur at this interface (last word always yields >=1 pad byte).

Reset
REQ-023 Reset asserted SHALL immediately clear cnt, pad_state, done and out (out=0, out_ready=0, buffer_full=0), including mid-block or mid-padding; the partial block is discarded.

Configuration
REQ-024 Macro PADDER_ASSERT_EN: when defined, embedded assertions check out_ready==buffer_full, no update while buffer_full, and byte_num known when is_last&in_ready; when undefined, no assertion logic is compiled and function is identical.

Structure
REQ-025 Shared package padder_pkg SHALL hold WORD_W=32, RATE_W=576, WORDS=18, PAD_FIRST=8'h01, PAD_LAST=8'h80.
REQ-026 One combinational sub-module padder_word_pad SHALL implement REQ-015.

Verification
REQ-027 Empty message: after reset, in_ready=1,is_last=1,in=0,byte_num=0 for two cycles -> out={8'h01,560'h0,8'h80}; after f_ack, buffer_full stays 0 for 5 cycles.
REQ-028 568-bit message: 18 words alternating 12345678/90ABCDEF, last with is_last, byte_num=3 -> out={8{64'h1234567890ABCDEF},64'h1234567890ABCD81}.
REQ-029 512-bit message: 16 words, then is_last,byte_num=0 -> two cycles later out={8{64'h1234567890ABCDEF},64'h0100000000000080}.
REQ-030 Two blocks: 18 words without is_last -> out_ready=1, out={9{64'h1234567890ABCDEF}}; in=999 held 2 cycles not eaten (buffer_full=1); f_ack -> out_ready=0; 18 words, last with byte_num=2 -> out={8{...},64'h1234567890AB0180}.
REQ-031 After second block f_ack with in_ready=0 -> out_ready=0 for 10 cycles.
REQ-032 Reset mid-block (after 5 words) -> buffer_full=0, out=0; next full message pads correctly.
